// File: rtl/edac_4bit_sched_pkg.sv
// Shared types for the 4-bit LUT EDAC scheduler: FSM states, grant encoding
// and the polynomial loaded on reset.
// No ports; imported by the interface, arbiter and top.
package edac_4bit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  localparam logic [3:0] CRC_RST_DEF = 4'b0011;

endpackage

// File: rtl/edac_4bit_sched_if.sv
// Bundle of requester, config and EDAC-datapath signals around the scheduler.
// slave  : the scheduler's view (takes requests, drives acks and EDAC inputs).
// master : the surrounding logic's view (requesters, config, EDAC datapath).
interface edac_4bit_sched_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 cfg_we;
  logic [3:0]           cfg_crc;
  logic                 wr_req;
  logic [15:0]          wr_data;
  logic                 wr_ack;
  logic [15:0]          wr_code;
  logic                 rd_req;
  logic [15:0]          rd_code;
  logic                 rd_ack;
  logic [15:0]          rd_data;
  logic                 rd_err;
  logic                 edac_en;
  logic                 edac_read;
  logic [15:0]          edac_din;
  logic [3:0]           edac_crc;
  logic [15:0]          edac_dout;
  logic                 edac_valid;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  cfg_we, cfg_crc, wr_req, wr_data, rd_req, rd_code, edac_dout, edac_valid,
    output wr_ack, wr_code, rd_ack, rd_data, rd_err,
    output edac_en, edac_read, edac_din, edac_crc, busy, err_cnt
  );

  modport master (
    output cfg_we, cfg_crc, wr_req, wr_data, rd_req, rd_code, edac_dout, edac_valid,
    input  wr_ack, wr_code, rd_ack, rd_data, rd_err,
    input  edac_en, edac_read, edac_din, edac_crc, busy, err_cnt
  );

endinterface

// File: rtl/edac_4bit_sched_arb.sv
// Two-input round-robin arbiter: req[0] = write, req[1] = read.
// Ports: clk/rst, req, advance (grant consumed) -> gnt, gnt_vld, last_grant.
// On a tie the requester that did not win last time is chosen.
module edac_rr_arb2
  import edac_4bit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic [1:0] req,
  input  logic   advance,
  output logic   gnt_vld,
  output grant_t gnt,
  output grant_t last_grant
);

  always_comb begin
    gnt_vld = |req;
    gnt     = GNT_WR;
    if (req == 2'b11)
      gnt = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    else if (req[1])
      gnt = GNT_RD;
  end

  // Starts as WR so that the first tie after reset goes to the reader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= GNT_WR;
    else if (advance)
      last_grant <= gnt;
  end

endmodule

// File: rtl/edac_4bit_sched.sv
// Shares one LUT EDAC unit between a write-encode and a read-decode requester,
// holding EDAC inputs stable for the LUT latency and returning one-cycle acks.
// Ports: CLK/reset, bus (slave view of edac_4bit_sched_if). Ack at t+LUT_LAT+2.
module edac_4bit_sched
  import edac_4bit_pkg::*;
#(
  parameter int         LUT_LAT   = 1,
  parameter int         ERR_CNT_W = 8,
  parameter logic [3:0] CRC_RST   = CRC_RST_DEF
) (
  input logic CLK,
  input logic reset,
  edac_4bit_sched_if.slave bus
);

  localparam logic [1:0] LAT_LAST = 2'(LUT_LAT - 1);

  state_t     state, state_nxt;
  logic [1:0] lat_cnt;
  logic       advance;
  logic       gnt_vld;
  grant_t     gnt;
  grant_t     last_grant;

  edac_rr_arb2 u_arb (
    .clk        (CLK),
    .rst        (reset),
    .req        ({bus.rd_req, bus.wr_req}),
    .advance    (advance),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  // A config write in IDLE blocks the grant for that cycle; the request is
  // still pending and gets granted the following cycle.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld && !bus.cfg_we) begin
          state_nxt = LOOKUP;
          advance   = 1'b1;
        end
      end
      LOOKUP:  if (lat_cnt == LAT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= (state == LOOKUP) ? lat_cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)
      bus.edac_crc <= CRC_RST;
    else if (state == IDLE && bus.cfg_we)
      bus.edac_crc <= bus.cfg_crc;
  end

  // EDAC inputs are latched at grant and left untouched until RESP, where
  // only the enable drops.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bus.edac_en   <= 1'b0;
      bus.edac_read <= 1'b0;
      bus.edac_din  <= 16'h0000;
    end else if (advance) begin
      bus.edac_en   <= 1'b1;
      bus.edac_read <= (gnt == GNT_RD);
      bus.edac_din  <= (gnt == GNT_RD) ? bus.rd_code : bus.wr_data;
    end else if (state == CAPTURE) begin
      bus.edac_en   <= 1'b0;
    end
  end

  // Results are registered on the CAPTURE->RESP edge, so acks and data are
  // visible together throughout RESP.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bus.wr_ack  <= 1'b0;
      bus.wr_code <= 16'h0000;
      bus.rd_ack  <= 1'b0;
      bus.rd_data <= 16'h0000;
      bus.rd_err  <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.wr_ack <= (state == CAPTURE) && !bus.edac_read;
      bus.rd_ack <= (state == CAPTURE) &&  bus.edac_read;
      if (state == CAPTURE) begin
        if (bus.edac_read) begin
          bus.rd_data <= bus.edac_dout;
          bus.rd_err  <= ~bus.edac_valid;
          if (!bus.edac_valid && bus.err_cnt != {ERR_CNT_W{1'b1}})
            bus.err_cnt <= bus.err_cnt + 1'b1;
        end else begin
          bus.wr_code <= bus.edac_dout;
        end
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_edac_4bit_sched.sv
// Scoreboard bench for edac_4bit_sched: requester tasks push expected acks
// (data, error flag, counter, cycle) into queues; negedge monitors pop and compare.
// Two DUTs: LUT_LAT=1 (main) and LUT_LAT=3 (latency check).
module tb_edac_4bit_sched;
  import edac_4bit_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  edac_4bit_sched_if #(.ERR_CNT_W(8)) b1();
  edac_4bit_sched_if #(.ERR_CNT_W(8)) b3();

  edac_4bit_sched #(.LUT_LAT(1), .ERR_CNT_W(8)) dut1 (.CLK(clk), .reset(reset), .bus(b1.slave));
  edac_4bit_sched #(.LUT_LAT(3), .ERR_CNT_W(8)) dut3 (.CLK(clk), .reset(reset), .bus(b3.slave));

  // EDAC datapath model: decode returns low byte, encode XORs with A5A5.
  logic mv1 = 1'b1;
  always_comb begin
    b1.edac_dout  = b1.edac_en ? (b1.edac_read ? {8'h00, b1.edac_din[7:0]}
                                               : b1.edac_din ^ 16'hA5A5) : 16'hDEAD;
    b1.edac_valid = b1.edac_en & mv1;
    b3.edac_dout  = b3.edac_en ? (b3.edac_read ? {8'h00, b3.edac_din[7:0]}
                                               : b3.edac_din ^ 16'hA5A5) : 16'hDEAD;
    b3.edac_valid = b3.edac_en;
  end

  typedef struct { logic [15:0] data; logic err; logic [7:0] cnt; int cyc; } rd_exp_t;
  typedef struct { logic [15:0] code; int cyc; } wr_exp_t;

  rd_exp_t rdq1[$];
  wr_exp_t wrq1[$];
  wr_exp_t wrq3[$];
  logic [7:0] exp_cnt = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitors
  always @(negedge clk) begin : mon_rd1
    rd_exp_t e;
    if (b1.rd_ack) begin
      if (rdq1.size() == 0) flag("rd_ack_unexpected");
      else begin
        e = rdq1.pop_front();
        chk("rd_data", b1.rd_data, e.data);
        chk("rd_err", b1.rd_err, e.err);
        chk("err_cnt", b1.err_cnt, e.cnt);
        chk("rd_ack_cycle", cyc, e.cyc);
        chk("rd_wr_ack_excl", b1.wr_ack, 1'b0);
      end
    end
  end

  always @(negedge clk) begin : mon_wr1
    wr_exp_t e;
    if (b1.wr_ack) begin
      if (wrq1.size() == 0) flag("wr_ack_unexpected");
      else begin
        e = wrq1.pop_front();
        chk("wr_code", b1.wr_code, e.code);
        chk("wr_ack_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_wr3
    wr_exp_t e;
    if (b3.rd_ack) flag("lat3_rd_ack_unexpected");
    if (b3.wr_ack) begin
      if (wrq3.size() == 0) flag("lat3_wr_ack_unexpected");
      else begin
        e = wrq3.pop_front();
        chk("lat3_wr_code", b3.wr_code, e.code);
        chk("lat3_wr_ack_cycle", cyc, e.cyc);
      end
    end
  end

  // EDAC inputs must not move while enabled.
  logic        en_p  = 1'b0;
  logic        rdm_p = 1'b0;
  logic [15:0] din_p = 16'h0;
  always @(negedge clk) begin : mon_stable
    if (b1.edac_en && en_p) begin
      chk("edac_din_stable", b1.edac_din, din_p);
      chk("edac_read_stable", b1.edac_read, rdm_p);
    end
    en_p  = b1.edac_en;
    rdm_p = b1.edac_read;
    din_p = b1.edac_din;
  end

  // Requesters (called at a negedge in an IDLE cycle)
  task automatic do_rd(input logic [15:0] code, input logic [15:0] exp_data,
                       input logic exp_err, input int lat);
    rd_exp_t e;
    bit got = 0;
    mv1 = ~exp_err;
    b1.rd_code = code;
    b1.rd_req  = 1'b1;
    if (exp_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
    e.data = exp_data; e.err = exp_err; e.cnt = exp_cnt; e.cyc = cyc + lat;
    rdq1.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b1.rd_ack) begin got = 1; break; end
    end
    if (!got) flag("rd_ack_timeout");
    b1.rd_req = 1'b0;
  endtask

  task automatic do_wr(input int sel, input logic [15:0] data,
                       input logic [15:0] exp_code, input int lat);
    wr_exp_t e;
    bit got = 0;
    e.code = exp_code; e.cyc = cyc + lat;
    if (sel == 1) begin
      b1.wr_data = data; b1.wr_req = 1'b1; wrq1.push_back(e);
    end else begin
      b3.wr_data = data; b3.wr_req = 1'b1; wrq3.push_back(e);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel == 1) ? b1.wr_ack : b3.wr_ack) begin got = 1; break; end
    end
    if (!got) flag("wr_ack_timeout");
    if (sel == 1) b1.wr_req = 1'b0; else b3.wr_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    b1.cfg_we = 0; b1.cfg_crc = 0; b1.wr_req = 0; b1.wr_data = 0; b1.rd_req = 0; b1.rd_code = 0;
    b3.cfg_we = 0; b3.cfg_crc = 0; b3.wr_req = 0; b3.wr_data = 0; b3.rd_req = 0; b3.rd_code = 0;
    exp_cnt = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    b1.cfg_we = 0; b1.cfg_crc = 0; b1.wr_req = 0; b1.wr_data = 0; b1.rd_req = 0; b1.rd_code = 0;
    b3.cfg_we = 0; b3.cfg_crc = 0; b3.wr_req = 0; b3.wr_data = 0; b3.rd_req = 0; b3.rd_code = 0;
    #2;
    reset = 1'b1;
    @(negedge clk);
    // Reset state
    chk("rst_busy", b1.busy, 1'b0);
    chk("rst_edac_en", b1.edac_en, 1'b0);
    chk("rst_edac_din", b1.edac_din, 16'h0);
    chk("rst_edac_read", b1.edac_read, 1'b0);
    chk("rst_edac_crc", b1.edac_crc, 4'h3);
    chk("rst_acks", {b1.wr_ack, b1.rd_ack}, 2'b00);
    chk("rst_outs", {b1.wr_code, b1.rd_data, b1.rd_err}, 33'h0);
    chk("rst_err_cnt", b1.err_cnt, 8'h00);
    chk("rst_lat3_crc", b3.edac_crc, 4'h3);
    do_reset();

    // 1: single read, ack at t+3
    do_rd(16'h0A55, 16'h0055, 1'b0, 3);
    @(negedge clk);

    // 2: simultaneous requests after reset; read wins the first tie
    do_reset();
    fork
      do_rd(16'h0B3C, 16'h003C, 1'b0, 3);
      do_wr(1, 16'h1234, 16'hB791, 7);
      begin
        @(negedge clk);
        chk("t2_first_en", b1.edac_en, 1'b1);
        chk("t2_first_is_read", b1.edac_read, 1'b1);
        chk("t2_first_din", b1.edac_din, 16'h0B3C);
        repeat (4) @(negedge clk);
        chk("t2_second_en", b1.edac_en, 1'b1);
        chk("t2_second_is_write", b1.edac_read, 1'b0);
        chk("t2_second_din", b1.edac_din, 16'h1234);
      end
    join
    chk("t2_rd_data_held", b1.rd_data, 16'h003C);
    @(negedge clk);

    // 3: 260 uncorrectable reads; counter saturates
    for (int k = 0; k < 260; k++) begin
      do_rd(16'h0C0F, 16'h000F, 1'b1, 3);
      @(negedge clk);
    end
    chk("t3_err_cnt_sat", b1.err_cnt, 8'hFF);
    mv1 = 1'b1;

    // 4: cfg_we beats a same-cycle write; cfg_we while busy is dropped
    fork
      do_wr(1, 16'h00FF, 16'hA55A, 4);
      begin
        b1.cfg_we = 1'b1; b1.cfg_crc = 4'hB;
        @(negedge clk);
        b1.cfg_we = 1'b0;
        chk("t4_crc_loaded", b1.edac_crc, 4'hB);
        chk("t4_not_yet_busy", b1.busy, 1'b0);
        @(negedge clk);
        chk("t4_busy", b1.busy, 1'b1);
        b1.cfg_we = 1'b1; b1.cfg_crc = 4'h5;
        @(negedge clk);
        b1.cfg_we = 1'b0;
        chk("t4_crc_kept_busy", b1.edac_crc, 4'hB);
      end
    join
    @(negedge clk);

    // 5: reset during LOOKUP aborts the read
    b1.rd_code = 16'h0A55;
    b1.rd_req  = 1'b1;
    @(negedge clk);
    chk("t5_in_lookup", b1.busy, 1'b1);
    reset = 1'b1;
    b1.rd_req = 1'b0;
    #1;
    chk("t5_busy", b1.busy, 1'b0);
    chk("t5_edac_en", b1.edac_en, 1'b0);
    chk("t5_edac_crc", b1.edac_crc, 4'h3);
    chk("t5_err_cnt", b1.err_cnt, 8'h00);
    exp_cnt = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_ack", {b1.rd_ack, b1.wr_ack}, 2'b00);
    end

    // 6: LUT_LAT=3 write, ack at t+5
    do_wr(3, 16'h5A0F, 16'hFFAA, 5);
    repeat (3) @(negedge clk);

    chk("rdq_drained", rdq1.size(), 0);
    chk("wrq_drained", wrq1.size(), 0);
    chk("wrq3_drained", wrq3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
